clkgen_div: RTL and testbench
=============================

Name: clkgen_div

Overview:
- Multi-channel programmable clock divider; successor to the fixed single-ratio divider.
- Generates NCH divided clocks from clk_in, each with its own runtime-loadable divisor, enable, rising-edge tick strobe and synchronous reset output.
- Sits at the top-level clocking layer and feeds slow peripheral domains (VGA, UART, audio) with divided clocks, tick strobes and their resets.

Parameters:
- NCH, 2, number of output channels (>=1).
- W, 8, divisor and counter width in bits (>=2).
- DIV_RST, 4, divisor loaded into every channel on reset (2 <= DIV_RST < 2**W).
- RST_CYC, 2, number of clk_out rising edges rst_out stays high after reset/enable (>=1).

Ports:
- clk_in  in  1  input clock; the block has one clock.
- rst_in  in  1  synchronous, active-high reset.
- en  in  NCH  per-channel enable.
- div_in  in  NCH*W  divisor bus; channel i uses bits [i*W +: W].
- div_ld  in  NCH  per-channel divisor load strobe.
- sync_in  in  1  phase-align strobe; port exists only with CLKGEN_SYNC_EN.
- clk_out  out  NCH  divided clocks.
- tick  out  NCH  1-cycle pulse, asserted in the same clk_in cycle that clk_out[i] rises.
- rst_out  out  NCH  per-channel reset, active-high.
- div_cur  out  NCH*W  active divisor of each channel.

Behaviour:
Interface and reset
- All outputs are registered; single clock clk_in; rst_in is synchronous and active-high.
- rst_in=1 sets, for every channel: clk_out=0, tick=0, rst_out=1, counter=0, active divisor and shadow divisor = DIV_RST, div_cur=DIV_RST, edge count=0.
- rst_in asserted mid-period aborts the period immediately, with no partial high phase.

Divisor and waveform
- Effective divisor N = max(value, 2); a value of 0 or 1 is clamped to 2.
- div_cur reports the clamped active value.
- Period is N clk_in cycles: clk_out low for ceil(N/2) cycles, then high for floor(N/2) cycles.
- Counter runs 0..N-1. clk_out goes 1 on the register update that leaves count ceil(N/2)-1 (tick=1 in that cycle). It goes 0 when the counter wraps N-1 -> 0.
- Example, N=5: low 3 cycles, high 2 cycles.

Loading
- div_ld[i]=1 captures div_in[i] into the shadow register and sets a pending flag.
- The shadow is applied only at a period boundary (counter wrap), so no runt pulses occur.
- div_ld in the same cycle as a wrap: the new value takes effect at that same boundary (bypass path).
- Back-to-back loads within one period: last value wins.

Enable
- en[i]=0: clk_out=0, tick=0, counter=0, rst_out=1, edge count=0. The shadow register is still loadable.
- A pending value applies as soon as the channel is disabled.
- en[i] 0->1: the first low phase starts on the next cycle.

Reset release
- rst_out[i] falls in the cycle of the RST_CYC-th tick[i] after rst_in=0 and en[i]=1.
- Edge counter saturates at RST_CYC.

Channels
- Channels are fully independent; no shared state except rst_in and sync_in.

Optional Feature:
CLKGEN_SYNC_EN
- Defined: adds the sync_in port. sync_in=1 forces every enabled channel to counter=0 and clk_out=0 in the next cycle, applying pending divisors, so all channels restart phase-aligned. rst_out is unaffected. sync_in together with rst_in: reset wins.
- Undefined: the sync_in port and its logic are absent; the rest of the behaviour is identical.

Decomposition:
- Package clkgen_pkg holds:
  - typedef div_t (logic [W-1:0], via package parameter default 8);
  - localparam DIV_MIN = 2;
  - the clamp function div_clamp.
- Sub-module clkgen_div_ch implements one channel (counter, shadow, pending flag, edge counter, outputs). The top instantiates NCH copies in a generate loop and slices the buses.

Test Plan:
- Reset release, DIV_RST=4, RST_CYC=2, en=all 1: after rst_in falls, clk_out shows period 4 (low 2, high 2). tick pulses every 4 cycles. rst_out falls on the 2nd tick.
- Odd divisor: load div_in=5 on ch0 -> after the current period ends, low 3 / high 2. div_cur=5 from the boundary cycle on.
- Clamp: load values 0 and 1 -> behaves as N=2 (toggles every cycle). div_cur=2.
- Load-at-wrap and double load: div_ld with 6 in the wrap cycle -> the next period is 6. Loads of 7 then 3 inside one period -> the next period is 3, and no period shorter than min(old,new) appears.
- Enable/disable mid-high-phase: en[1]=0 -> clk_out[1]=0 and rst_out[1]=1 next cycle. Re-enable -> rst_out[1] falls after 2 ticks. Ch0 is undisturbed throughout.
- With CLKGEN_SYNC_EN, ch0 N=4, ch1 N=8, sync_in pulse at an arbitrary phase -> both counters=0 next cycle, and rising edges coincide every 8 cycles. rst_in during the pulse -> the reset state is observed.

Source files
------------

// File: rtl/clkgen_pkg.sv
// clkgen_pkg: shared divisor type, minimum divisor and clamp helper for clkgen_div.
// Latency: n/a (package). Backpressure: n/a.
// Ports: none.
package clkgen_pkg;

  parameter int DIV_W = 8;
  typedef logic [DIV_W-1:0] div_t;

  localparam int DIV_MIN = 2;

  // Divisors below DIV_MIN cannot form a low and a high phase, so they are raised to DIV_MIN.
  function automatic logic [31:0] div_clamp(input logic [31:0] v);
    return (v < 32'(DIV_MIN)) ? 32'(DIV_MIN) : v;
  endfunction

endpackage

// File: rtl/clkgen_div_ch.sv
// clkgen_div_ch: one divided-clock channel with shadowed divisor, tick strobe and reset output.
// Latency: all outputs registered, one clk_in cycle from inputs. Backpressure: none, free running.
// Ports: clk_in/rst_in (sync, active-high), en, div_in/div_ld (shadow load), sync_in (only with
//        CLKGEN_SYNC_EN), clk_out, tick, rst_out, div_cur (clamped active divisor).
module clkgen_div_ch
  import clkgen_pkg::*;
#(
  parameter int W       = 8,
  parameter int DIV_RST = 4,
  parameter int RST_CYC = 2
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         en,
  input  logic [W-1:0] div_in,
  input  logic         div_ld,
`ifdef CLKGEN_SYNC_EN
  input  logic         sync_in,
`endif
  output logic         clk_out,
  output logic         tick,
  output logic         rst_out,
  output logic [W-1:0] div_cur
);

  localparam int            EW       = $clog2(RST_CYC + 1);
  localparam logic [EW-1:0] ECNT_MAX = EW'(RST_CYC);

  logic [W-1:0]  cnt_q, cnt_d;
  logic [W-1:0]  act_q, act_d;
  logic [W-1:0]  shd_q, shd_d;
  logic          pend_q, pend_d;
  logic [EW-1:0] ecnt_q, ecnt_d;
  logic          clk_q, clk_d;
  logic          tick_q, tick_d;
  logic          rst_q, rst_d;
  logic          boundary;

  // Low phase is ceil(N/2) cycles; computed one bit wider so N = 2**W-1 cannot overflow.
  logic [W:0] lo_len;
  logic       wrap;
  logic       rise;

  assign lo_len = ({1'b0, act_q} + 1'b1) >> 1;
  assign wrap   = (cnt_q == act_q - 1'b1);
  assign rise   = ({1'b0, cnt_q} == lo_len - 1'b1);

  always_comb begin
    cnt_d    = cnt_q;
    act_d    = act_q;
    shd_d    = shd_q;
    pend_d   = pend_q;
    ecnt_d   = ecnt_q;
    clk_d    = clk_q;
    tick_d   = 1'b0;
    rst_d    = rst_q;
    boundary = 1'b0;

    if (div_ld) begin
      shd_d  = div_in;
      pend_d = 1'b1;
    end

    if (!en) begin
      cnt_d    = '0;
      clk_d    = 1'b0;
      rst_d    = 1'b1;
      ecnt_d   = '0;
      boundary = 1'b1;
    end
`ifdef CLKGEN_SYNC_EN
    else if (sync_in) begin
      // Phase restart: reset output and edge count are deliberately left alone.
      cnt_d    = '0;
      clk_d    = 1'b0;
      boundary = 1'b1;
    end
`endif
    else if (wrap) begin
      cnt_d    = '0;
      clk_d    = 1'b0;
      boundary = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
      if (rise) begin
        clk_d  = 1'b1;
        tick_d = 1'b1;
        if (ecnt_q != ECNT_MAX) begin
          ecnt_d = ecnt_q + 1'b1;
        end
        if (ecnt_d == ECNT_MAX) begin
          rst_d = 1'b0;
        end
      end
    end

    // A load arriving on the boundary cycle bypasses the shadow so it lands on this boundary.
    if (boundary && (div_ld || pend_q)) begin
      act_d  = W'(div_clamp(32'(div_ld ? div_in : shd_q)));
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q  <= '0;
      act_q  <= W'(div_clamp(32'(DIV_RST)));
      shd_q  <= W'(DIV_RST);
      pend_q <= 1'b0;
      ecnt_q <= '0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
      rst_q  <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      shd_q  <= shd_d;
      pend_q <= pend_d;
      ecnt_q <= ecnt_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
      rst_q  <= rst_d;
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;
  assign rst_out = rst_q;
  assign div_cur = act_q;

endmodule

// File: rtl/clkgen_div.sv
// clkgen_div: NCH independent programmable clock dividers off clk_in, with ticks and resets.
// Latency: all outputs registered, one clk_in cycle. Backpressure: none, free running.
// Ports: clk_in, rst_in (sync, active-high), en[NCH], div_in[NCH*W], div_ld[NCH],
//        sync_in (present only when CLKGEN_SYNC_EN is defined), clk_out/tick/rst_out[NCH],
//        div_cur[NCH*W]. Channel i uses bit i and bus slice [i*W +: W].
module clkgen_div
  import clkgen_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int W       = 8,
  parameter int DIV_RST = 4,
  parameter int RST_CYC = 2
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [NCH-1:0]   en,
  input  logic [NCH*W-1:0] div_in,
  input  logic [NCH-1:0]   div_ld,
`ifdef CLKGEN_SYNC_EN
  input  logic             sync_in,
`endif
  output logic [NCH-1:0]   clk_out,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   rst_out,
  output logic [NCH*W-1:0] div_cur
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    clkgen_div_ch #(
      .W       (W),
      .DIV_RST (DIV_RST),
      .RST_CYC (RST_CYC)
    ) u_ch (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .en      (en[i]),
      .div_in  (div_in[i*W +: W]),
      .div_ld  (div_ld[i]),
`ifdef CLKGEN_SYNC_EN
      .sync_in (sync_in),
`endif
      .clk_out (clk_out[i]),
      .tick    (tick[i]),
      .rst_out (rst_out[i]),
      .div_cur (div_cur[i*W +: W])
    );
  end

endmodule

// File: tb/tb_clkgen_div.sv
// tb_clkgen_div: scoreboard bench for clkgen_div (NCH=2, W=8, DIV_RST=4, RST_CYC=2).
// Expected periods are queued as divisors are programmed and popped as whole periods are measured.
// Sync-align scenario is included only when CLKGEN_SYNC_EN is defined.
module tb_clkgen_div;

  localparam int NCH = 2;
  localparam int W   = 8;

  logic             clk_in;
  logic             rst_in;
  logic [NCH-1:0]   en;
  logic [NCH*W-1:0] div_in;
  logic [NCH-1:0]   div_ld;
`ifdef CLKGEN_SYNC_EN
  logic             sync_in;
`endif
  logic [NCH-1:0]   clk_out;
  logic [NCH-1:0]   tick;
  logic [NCH-1:0]   rst_out;
  logic [NCH*W-1:0] div_cur;

  typedef struct {
    int ch;
    int n;
  } sb_t;

  sb_t sb[$];
  sb_t e;
  int  checks;
  int  failures;
  int  lo, hi, tk;
  bit  ok;

  clkgen_div #(.NCH(NCH), .W(W), .DIV_RST(4), .RST_CYC(2)) dut (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .en      (en),
    .div_in  (div_in),
    .div_ld  (div_ld),
`ifdef CLKGEN_SYNC_EN
    .sync_in (sync_in),
`endif
    .clk_out (clk_out),
    .tick    (tick),
    .rst_out (rst_out),
    .div_cur (div_cur)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Returns at the first negedge sample after clk_out[c] falls (first low cycle of a period).
  task automatic align(input int c, output bit found);
    logic prev;
    prev  = clk_out[c];
    found = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk_in);
      if (prev && !clk_out[c]) begin
        found = 1'b1;
        return;
      end
      prev = clk_out[c];
    end
  endtask

  // Counts the rest of the current period; lo0 low samples have already been seen.
  task automatic measure(input int c, input int lo0, output int nlo, output int nhi,
                         output int nt, output bit done);
    nlo  = lo0;
    nhi  = 0;
    nt   = 0;
    done = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk_in);
      if (!clk_out[c] && nhi > 0) begin
        done = 1'b1;
        return;
      end
      if (tick[c]) nt++;
      if (clk_out[c]) nhi++;
      else nlo++;
    end
  endtask

  task automatic test_reset();
    logic [1:0] exp_tick;
    logic [1:0] exp_rst;
    rst_in = 1'b1;
    en     = 2'b11;
    div_ld = 2'b00;
    div_in = '0;
`ifdef CLKGEN_SYNC_EN
    sync_in = 1'b0;
`endif
    repeat (3) @(negedge clk_in);
    checks++;
    if (clk_out !== 2'b00) begin failures++; $display("FAIL reset_clk_out: got %b want 00", clk_out); end
    checks++;
    if (tick !== 2'b00) begin failures++; $display("FAIL reset_tick: got %b want 00", tick); end
    checks++;
    if (rst_out !== 2'b11) begin failures++; $display("FAIL reset_rst_out: got %b want 11", rst_out); end
    checks++;
    if (div_cur !== {8'd4, 8'd4}) begin failures++; $display("FAIL reset_div_cur: got %h want 0404", div_cur); end

    rst_in = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk_in);
      exp_tick = (k == 2 || k == 6) ? 2'b11 : 2'b00;
      exp_rst  = (k < 6) ? 2'b11 : 2'b00;
      checks++;
      if (tick !== exp_tick || rst_out !== exp_rst) begin
        failures++;
        $display("FAIL release_seq k=%0d: tick=%b rst_out=%b want tick=%b rst_out=%b", k, tick, rst_out, exp_tick, exp_rst);
      end
    end

    align(0, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL reset_align: no falling edge on ch0"); end
    for (int p = 0; p < 3; p++) sb.push_back('{ch: 0, n: 4});
    for (int p = 0; p < 3; p++) begin
      measure(0, 1, lo, hi, tk, ok);
      checks++;
      if (sb.size() == 0) begin failures++; $display("FAIL reset_period: scoreboard empty"); end
      else begin
        e = sb.pop_front();
        if (!ok || e.ch != 0 || lo != (e.n + 1) / 2 || hi != e.n / 2 || tk != 1) begin
          failures++;
          $display("FAIL reset_period: lo=%0d hi=%0d ticks=%0d done=%0d want lo=%0d hi=%0d ticks=1", lo, hi, tk, ok, (e.n + 1) / 2, e.n / 2);
        end
      end
    end
  endtask

  task automatic test_odd_div();
    sb.push_back('{ch: 0, n: 4});
    sb.push_back('{ch: 0, n: 5});
    sb.push_back('{ch: 0, n: 5});
    div_in[7:0] = 8'd5;
    div_ld      = 2'b01;
    @(negedge clk_in);
    div_ld = 2'b00;
    checks++;
    if (div_cur[7:0] !== 8'd4) begin failures++; $display("FAIL odd_div_cur_early: got %0d want 4", div_cur[7:0]); end
    for (int p = 0; p < 3; p++) begin
      measure(0, (p == 0) ? 2 : 1, lo, hi, tk, ok);
      checks++;
      if (sb.size() == 0) begin failures++; $display("FAIL odd_period: scoreboard empty"); end
      else begin
        e = sb.pop_front();
        if (!ok || e.ch != 0 || lo != (e.n + 1) / 2 || hi != e.n / 2 || tk != 1) begin
          failures++;
          $display("FAIL odd_period p=%0d: lo=%0d hi=%0d ticks=%0d done=%0d want lo=%0d hi=%0d ticks=1", p, lo, hi, tk, ok, (e.n + 1) / 2, e.n / 2);
        end
      end
      if (p == 0) begin
        checks++;
        if (div_cur !== {8'd4, 8'd5}) begin failures++; $display("FAIL odd_div_cur: got %h want 0405", div_cur); end
      end
    end
  endtask

  task automatic test_clamp();
    sb.push_back('{ch: 0, n: 5});
    sb.push_back('{ch: 0, n: 2});
    sb.push_back('{ch: 0, n: 2});
    div_in[7:0] = 8'd0;
    div_ld      = 2'b01;
    @(negedge clk_in);
    div_ld = 2'b00;
    for (int p = 0; p < 3; p++) begin
      measure(0, (p == 0) ? 2 : 1, lo, hi, tk, ok);
      checks++;
      if (sb.size() == 0) begin failures++; $display("FAIL clamp0_period: scoreboard empty"); end
      else begin
        e = sb.pop_front();
        if (!ok || e.ch != 0 || lo != (e.n + 1) / 2 || hi != e.n / 2 || tk != 1) begin
          failures++;
          $display("FAIL clamp0_period p=%0d: lo=%0d hi=%0d ticks=%0d done=%0d want lo=%0d hi=%0d ticks=1", p, lo, hi, tk, ok, (e.n + 1) / 2, e.n / 2);
        end
      end
      if (p == 0) begin
        checks++;
        if (div_cur[7:0] !== 8'd2) begin failures++; $display("FAIL clamp0_div_cur: got %0d want 2", div_cur[7:0]); end
      end
    end

    // Hold the load of 1 across a full period; it lands on the next boundary.
    sb.push_back('{ch: 0, n: 2});
    sb.push_back('{ch: 0, n: 2});
    div_in[7:0] = 8'd1;
    div_ld      = 2'b01;
    for (int p = 0; p < 2; p++) begin
      measure(0, 1, lo, hi, tk, ok);
      div_ld = 2'b00;
      checks++;
      if (sb.size() == 0) begin failures++; $display("FAIL clamp1_period: scoreboard empty"); end
      else begin
        e = sb.pop_front();
        if (!ok || e.ch != 0 || lo != (e.n + 1) / 2 || hi != e.n / 2 || tk != 1) begin
          failures++;
          $display("FAIL clamp1_period p=%0d: lo=%0d hi=%0d ticks=%0d done=%0d want lo=%0d hi=%0d ticks=1", p, lo, hi, tk, ok, (e.n + 1) / 2, e.n / 2);
        end
      end
    end
    checks++;
    if (div_cur[7:0] !== 8'd2) begin failures++; $display("FAIL clamp1_div_cur: got %0d want 2", div_cur[7:0]); end
  endtask

  task automatic test_load_at_wrap();
    // Back to N=4 first so the wrap cycle position is known.
    sb.push_back('{ch: 0, n: 2});
    sb.push_back('{ch: 0, n: 4});
    div_in[7:0] = 8'd4;
    div_ld      = 2'b01;
    for (int p = 0; p < 2; p++) begin
      measure(0, 1, lo, hi, tk, ok);
      div_ld = 2'b00;
      checks++;
      if (sb.size() == 0) begin failures++; $display("FAIL to4_period: scoreboard empty"); end
      else begin
        e = sb.pop_front();
        if (!ok || e.ch != 0 || lo != (e.n + 1) / 2 || hi != e.n / 2 || tk != 1) begin
          failures++;
          $display("FAIL to4_period p=%0d: lo=%0d hi=%0d ticks=%0d done=%0d want lo=%0d hi=%0d ticks=1", p, lo, hi, tk, ok, (e.n + 1) / 2, e.n / 2);
        end
      end
    end

    repeat (3) @(negedge clk_in);
    checks++;
    if (clk_out[0] !== 1'b1) begin failures++; $display("FAIL wrap_last_high: got %b want 1", clk_out[0]); end
    div_in[7:0] = 8'd6;
    div_ld      = 2'b01;
    @(negedge clk_in);
    div_ld = 2'b00;
    checks++;
    if (clk_out[0] !== 1'b0 || div_cur[7:0] !== 8'd6) begin
      failures++;
      $display("FAIL wrap_bypass: clk_out=%b div_cur=%0d want clk_out=0 div_cur=6", clk_out[0], div_cur[7:0]);
    end
    sb.push_back('{ch: 0, n: 6});
    sb.push_back('{ch: 0, n: 6});
    for (int p = 0; p < 2; p++) begin
      measure(0, 1, lo, hi, tk, ok);
      checks++;
      if (sb.size() == 0) begin failures++; $display("FAIL wrap_period: scoreboard empty"); end
      else begin
        e = sb.pop_front();
        if (!ok || e.ch != 0 || lo != (e.n + 1) / 2 || hi != e.n / 2 || tk != 1) begin
          failures++;
          $display("FAIL wrap_period p=%0d: lo=%0d hi=%0d ticks=%0d done=%0d want lo=%0d hi=%0d ticks=1", p, lo, hi, tk, ok, (e.n + 1) / 2, e.n / 2);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    sb.push_back('{ch: 0, n: 6});
    sb.push_back('{ch: 0, n: 3});
    sb.push_back('{ch: 0, n: 3});
    div_in[7:0] = 8'd7;
    div_ld      = 2'b01;
    @(negedge clk_in);
    div_in[7:0] = 8'd3;
    @(negedge clk_in);
    div_ld = 2'b00;
    for (int p = 0; p < 3; p++) begin
      measure(0, (p == 0) ? 3 : 1, lo, hi, tk, ok);
      checks++;
      if (sb.size() == 0) begin failures++; $display("FAIL b2b_period: scoreboard empty"); end
      else begin
        e = sb.pop_front();
        if (!ok || e.ch != 0 || lo != (e.n + 1) / 2 || hi != e.n / 2 || tk != 1) begin
          failures++;
          $display("FAIL b2b_period p=%0d: lo=%0d hi=%0d ticks=%0d done=%0d want lo=%0d hi=%0d ticks=1", p, lo, hi, tk, ok, (e.n + 1) / 2, e.n / 2);
        end
      end
      if (p == 0) begin
        checks++;
        if (div_cur[7:0] !== 8'd3) begin failures++; $display("FAIL b2b_div_cur: got %0d want 3", div_cur[7:0]); end
      end
    end
  endtask

  task automatic test_enable();
    int t0;
    t0 = 0;
    align(1, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL enable_align: no falling edge on ch1"); end
    checks++;
    if (rst_out[1] !== 1'b0) begin failures++; $display("FAIL enable_pre_rst: got %b want 0", rst_out[1]); end
    if (tick[0]) t0++;
    for (int k = 1; k < 24; k++) begin
      @(negedge clk_in);
      if (tick[0]) t0++;
      if (k == 2) begin
        checks++;
        if (clk_out[1] !== 1'b1) begin failures++; $display("FAIL enable_mid_high: got %b want 1", clk_out[1]); end
        en = 2'b01;
      end
      if (k == 3) begin
        checks++;
        if (clk_out[1] !== 1'b0 || rst_out[1] !== 1'b1 || tick[1] !== 1'b0) begin
          failures++;
          $display("FAIL disable: clk_out=%b rst_out=%b tick=%b want 0 1 0", clk_out[1], rst_out[1], tick[1]);
        end
      end
      if (k == 5) en = 2'b11;
      if (k == 7 || k == 11) begin
        checks++;
        if (tick[1] !== 1'b1) begin failures++; $display("FAIL reenable_tick k=%0d: got %b want 1", k, tick[1]); end
      end
      if (k == 10 || k == 11) begin
        checks++;
        if (rst_out[1] !== (k == 10)) begin failures++; $display("FAIL reenable_rst k=%0d: got %b want %b", k, rst_out[1], (k == 10)); end
      end
    end
    // ch0 runs at N=3, so any 24 consecutive cycles hold exactly 8 ticks.
    checks++;
    if (t0 != 8) begin failures++; $display("FAIL ch0_undisturbed: ticks=%0d want 8", t0); end
  endtask

`ifdef CLKGEN_SYNC_EN
  task automatic test_sync();
    logic [1:0] ex;
    div_in = {8'd8, 8'd4};
    div_ld = 2'b11;
    @(negedge clk_in);
    div_ld = 2'b00;
    @(negedge clk_in);
    sync_in = 1'b1;
    @(negedge clk_in);
    sync_in = 1'b0;
    checks++;
    if (clk_out !== 2'b00 || div_cur !== {8'd8, 8'd4}) begin
      failures++;
      $display("FAIL sync_restart: clk_out=%b div_cur=%h want 00 0804", clk_out, div_cur);
    end
    for (int k = 2; k <= 17; k++) begin
      @(negedge clk_in);
      ex[1] = ((k - 1) % 8) >= 4;
      ex[0] = ((k - 1) % 4) >= 2;
      checks++;
      if (clk_out !== ex) begin failures++; $display("FAIL sync_wave k=%0d: got %b want %b", k, clk_out, ex); end
    end
    checks++;
    if (rst_out !== 2'b00) begin failures++; $display("FAIL sync_rst_out: got %b want 00", rst_out); end
    rst_in  = 1'b1;
    sync_in = 1'b1;
    @(negedge clk_in);
    checks++;
    if (rst_out !== 2'b11 || clk_out !== 2'b00 || div_cur !== {8'd4, 8'd4}) begin
      failures++;
      $display("FAIL sync_vs_reset: rst_out=%b clk_out=%b div_cur=%h want 11 00 0404", rst_out, clk_out, div_cur);
    end
    rst_in  = 1'b0;
    sync_in = 1'b0;
  endtask
`endif

  task automatic test_reset_mid();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 32 && !seen; i++) begin
      @(negedge clk_in);
      if (clk_out[0]) seen = 1'b1;
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL reset_mid_wait: ch0 never high"); end
    rst_in = 1'b1;
    @(negedge clk_in);
    checks++;
    if (clk_out !== 2'b00 || tick !== 2'b00 || rst_out !== 2'b11 || div_cur !== {8'd4, 8'd4}) begin
      failures++;
      $display("FAIL reset_mid: clk_out=%b tick=%b rst_out=%b div_cur=%h want 00 00 11 0404", clk_out, tick, rst_out, div_cur);
    end
    rst_in = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_odd_div();
    test_clamp();
    test_load_at_wrap();
    test_back_to_back();
    test_enable();
`ifdef CLKGEN_SYNC_EN
    test_sync();
`endif
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_drain: %0d left want 0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
